// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pkg
// Purpose  : Shared types and constants for the RAM port arbiter.
//            - port_e : requester identity. It doubles as the bit index into
//                       the two-bit request/grant vectors.
//            - WORD_W : default RAM word width (NB_COL * COL_WIDTH).
//            - resp_t : one entry of the response stage {valid, port, err}.
// Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  localparam int unsigned COL_WIDTH_DEF = 8;
  localparam int unsigned NB_COL_DEF    = 4;
  localparam int unsigned WORD_W        = NB_COL_DEF * COL_WIDTH_DEF;

  typedef struct packed {
    logic  valid;
    port_e port;
    logic  err;
  } resp_t;

endpackage
`default_nettype wire

// File: rtl/ram_port_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-requester round-robin arbiter. The grant is combinational
//            from the requests and the last-granted port. On a conflict, the
//            port that was not granted last time wins.
// Ports    : clk       - clock, rising edge
//            rstn      - asynchronous active-low reset (last <= PORT_INSTR)
//            i_req[1:0]- requests, bit index = port_e
//            o_gnt[1:0]- one-hot grant, forced to 0 while in reset
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  port_e      r_last;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    // Gating with rstn keeps every grant, and so every RAM write, off
    // while the block is held in reset.
    if (rstn) begin
      case (i_req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = (r_last == PORT_INSTR) ? 2'b10 : 2'b01;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last <= PORT_INSTR;
    end else if (|w_gnt) begin
      r_last <= w_gnt[1] ? PORT_DATA : PORT_INSTR;
    end
  end

  assign o_gnt = w_gnt;

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Shares one single-port, byte-write, read-first BRAM between an
//            instruction-fetch port (read-only) and a data port (read/write).
//            It grants round-robin, checks address alignment and range, muxes
//            the RAM command, and returns a response one cycle after each
//            grant.
// Ports    : clk, rstn                         - clock / async active-low reset
//            i_req/i_addr -> i_gnt             - instruction request
//            i_rvalid/i_rdata/i_err            - instruction response
//            d_req/d_we/d_addr/d_wdata -> d_gnt- data request
//            d_rvalid/d_rdata/d_err            - data response
//            ram_we/ram_addr/ram_di, ram_dout  - RAM command / read data
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int SIZE       = 1024,
  parameter int ADDR_WIDTH = 32,
  parameter int COL_WIDTH  = 8,
  parameter int NB_COL     = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        i_req,
  input  logic [ADDR_WIDTH-1:0]       i_addr,
  output logic                        i_gnt,
  output logic                        i_rvalid,
  output logic [NB_COL*COL_WIDTH-1:0] i_rdata,
  output logic                        i_err,
  input  logic                        d_req,
  input  logic [NB_COL-1:0]           d_we,
  input  logic [ADDR_WIDTH-1:0]       d_addr,
  input  logic [NB_COL*COL_WIDTH-1:0] d_wdata,
  output logic                        d_gnt,
  output logic                        d_rvalid,
  output logic [NB_COL*COL_WIDTH-1:0] d_rdata,
  output logic                        d_err,
  output logic [NB_COL-1:0]           ram_we,
  output logic [ADDR_WIDTH-1:0]       ram_addr,
  output logic [NB_COL*COL_WIDTH-1:0] ram_di,
  input  logic [NB_COL*COL_WIDTH-1:0] ram_dout
);

  localparam int c_WORD_W = NB_COL * COL_WIDTH;

  logic [1:0]            w_gnt;
  logic                  w_any_gnt;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_aligned;
  logic                  w_in_range;
  logic                  w_legal;
  logic                  w_i_resp;
  logic                  w_d_resp;
  logic [c_WORD_W-1:0]   w_resp_data;

  resp_t                 r_resp;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [c_WORD_W-1:0]   r_i_rdata;
  logic [c_WORD_W-1:0]   r_d_rdata;
  logic                  r_i_err;
  logic                  r_d_err;

  rr_arb2 u_arb (
    .clk   (clk),
    .rstn  (rstn),
    .i_req ({d_req, i_req}),
    .o_gnt (w_gnt)
  );

  assign i_gnt     = w_gnt[0];
  assign d_gnt     = w_gnt[1];
  assign w_any_gnt = |w_gnt;
  assign w_addr    = w_gnt[1] ? d_addr : i_addr;

  // The word index is zero-extended, so out-of-range addresses fault
  // instead of aliasing back onto the RAM.
  assign w_aligned  = (w_addr[1:0] == 2'b00);
  assign w_in_range = ({2'b00, w_addr[ADDR_WIDTH-1:2]} < ADDR_WIDTH'(SIZE));
  assign w_legal    = w_aligned && w_in_range;

  assign ram_we   = (w_gnt[1] && w_legal) ? d_we : '0;
  assign ram_di   = w_gnt[1] ? d_wdata : '0;
  assign ram_addr = w_any_gnt ? w_addr : r_ram_addr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_resp     <= '0;
      r_ram_addr <= '0;
    end else begin
      r_resp.valid <= w_any_gnt;
      r_resp.port  <= w_gnt[1] ? PORT_DATA : PORT_INSTR;
      r_resp.err   <= !w_legal;
      if (w_any_gnt) begin
        r_ram_addr <= w_addr;
      end
    end
  end

  // ram_dout is valid in the response cycle, so the read data passes straight
  // through. The hold registers keep rdata/err stable between responses.
  assign w_i_resp    = r_resp.valid && (r_resp.port == PORT_INSTR);
  assign w_d_resp    = r_resp.valid && (r_resp.port == PORT_DATA);
  assign w_resp_data = r_resp.err ? '0 : ram_dout;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_i_rdata <= '0;
      r_i_err   <= 1'b0;
      r_d_rdata <= '0;
      r_d_err   <= 1'b0;
    end else begin
      if (w_i_resp) begin
        r_i_rdata <= w_resp_data;
        r_i_err   <= r_resp.err;
      end
      if (w_d_resp) begin
        r_d_rdata <= w_resp_data;
        r_d_err   <= r_resp.err;
      end
    end
  end

  assign i_rvalid = w_i_resp;
  assign i_rdata  = w_i_resp ? w_resp_data : r_i_rdata;
  assign i_err    = w_i_resp ? r_resp.err  : r_i_err;
  assign d_rvalid = w_d_resp;
  assign d_rdata  = w_d_resp ? w_resp_data : r_d_rdata;
  assign d_err    = w_d_resp ? r_resp.err  : r_d_err;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Purpose  : Self-checking bench for ram_port_arbiter. It contains a
//            read-first BRAM, a behavioural reference model that is compared
//            on every falling edge, directed scenarios with literal
//            expectations, and a randomized traffic phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

  localparam int SIZE = 1024;
  localparam int AW   = 32;
  localparam int IW   = $clog2(SIZE);

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_di;
  logic [31:0] ram_dout = '0;

  int total = 0;
  int bad   = 0;

  ram_port_arbiter #(.SIZE(SIZE), .ADDR_WIDTH(AW), .COL_WIDTH(8), .NB_COL(4)) dut (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int k);
    return (32'(k) * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- RAM: read-first, one-cycle registered output ----------
  logic [31:0] ram_mem [SIZE];
  bit          ram_init = 1'b0;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int k = 0; k < SIZE; k++) ram_mem[k] <= init_word(k);
      ram_init <= 1'b1;
    end else begin
      ram_dout <= ram_mem[ram_addr[IW+1:2]];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram_mem[ram_addr[IW+1:2]][b*8 +: 8] <= ram_di[b*8 +: 8];
    end
  end

  // ---------------- Reference model, checked on every falling edge --------
  logic [31:0] m_mem [SIZE];
  bit          m_init = 1'b0;
  bit          m_last;            // 0 = instruction granted last, 1 = data
  bit          m_pv, m_pp, m_pe;  // pending response: valid, port, err
  logic [31:0] m_pd;              // pending response data
  logic [31:0] m_i_rd, m_d_rd, m_last_addr;
  bit          m_i_er, m_d_er;
  bit          eg_i, eg_d, erv_i, erv_d, m_legal;
  logic [31:0] ga;

  always @(negedge clk) begin
    if (!m_init) begin
      for (int k = 0; k < SIZE; k++) m_mem[k] = init_word(k);
      m_init = 1'b1;
    end
    if (!rstn) begin
      chk("rst_i_gnt", 32'(i_gnt), 0);
      chk("rst_d_gnt", 32'(d_gnt), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_i_rvalid", 32'(i_rvalid), 0);
      chk("rst_d_rvalid", 32'(d_rvalid), 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_i_err", 32'(i_err), 0);
      chk("rst_d_err", 32'(d_err), 0);
      m_last = 0; m_pv = 0; m_pp = 0; m_pe = 0; m_pd = '0;
      m_i_rd = '0; m_d_rd = '0; m_i_er = 0; m_d_er = 0; m_last_addr = '0;
    end else begin
      if (i_req && d_req) begin
        eg_d = (m_last == 0);
        eg_i = !eg_d;
      end else begin
        eg_i = i_req;
        eg_d = d_req;
      end
      ga      = eg_d ? d_addr : i_addr;
      m_legal = (ga[1:0] == 2'b00) && (longint'(ga >> 2) < longint'(SIZE));
      erv_i   = m_pv && !m_pp;
      erv_d   = m_pv && m_pp;
      if (erv_i) begin m_i_rd = m_pd; m_i_er = m_pe; end
      if (erv_d) begin m_d_rd = m_pd; m_d_er = m_pe; end

      chk("i_gnt", 32'(i_gnt), 32'(eg_i));
      chk("d_gnt", 32'(d_gnt), 32'(eg_d));
      chk("ram_we", 32'(ram_we), (eg_d && m_legal) ? 32'(d_we) : 32'd0);
      chk("ram_di", ram_di, eg_d ? d_wdata : 32'd0);
      chk("ram_addr", ram_addr, (eg_i || eg_d) ? ga : m_last_addr);
      chk("i_rvalid", 32'(i_rvalid), 32'(erv_i));
      chk("d_rvalid", 32'(d_rvalid), 32'(erv_d));
      chk("i_rdata", i_rdata, m_i_rd);
      chk("d_rdata", d_rdata, m_d_rd);
      chk("i_err", 32'(i_err), 32'(m_i_er));
      chk("d_err", 32'(d_err), 32'(m_d_er));

      // Advance to the next cycle as the clock edge will.
      m_pv = eg_i || eg_d;
      m_pp = eg_d;
      m_pe = !m_legal;
      m_pd = m_legal ? m_mem[ga[IW+1:2]] : 32'd0;
      if (eg_d && m_legal)
        for (int b = 0; b < 4; b++)
          if (d_we[b]) m_mem[ga[IW+1:2]][b*8 +: 8] = d_wdata[b*8 +: 8];
      if (m_pv) begin
        m_last      = eg_d;
        m_last_addr = ga;
      end
    end
  end

  // ---------------- Directed helpers --------------------------------------
  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 0; i_req = 0; d_req = 0; d_we = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
  endtask

  task automatic d_txn(input string nm, input logic [3:0] we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] erd, input logic eerr);
    @(posedge clk); #1;
    d_req = 1; d_we = we; d_addr = a; d_wdata = wd;
    @(negedge clk);
    chk({nm, "_gnt"}, 32'(d_gnt), 1);
    chk({nm, "_we"}, 32'(ram_we), eerr ? 32'd0 : 32'(we));
    @(posedge clk); #1;
    d_req = 0; d_we = 0;
    @(negedge clk);
    chk({nm, "_rvalid"}, 32'(d_rvalid), 1);
    chk({nm, "_err"}, 32'(d_err), 32'(eerr));
    chk({nm, "_rdata"}, d_rdata, erd);
  endtask

  task automatic i_txn(input string nm, input logic [31:0] a,
                       input logic [31:0] erd, input logic eerr);
    @(posedge clk); #1;
    i_req = 1; i_addr = a;
    @(negedge clk);
    chk({nm, "_gnt"}, 32'(i_gnt), 1);
    @(posedge clk); #1;
    i_req = 0;
    @(negedge clk);
    chk({nm, "_rvalid"}, 32'(i_rvalid), 1);
    chk({nm, "_err"}, 32'(i_err), 32'(eerr));
    chk({nm, "_rdata"}, i_rdata, erd);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0: return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      1: return 32'h1000 + (32'($urandom_range(0, 3)) << 2);
      2: return 32'hFFC;
      3: return 32'($urandom);
      default: return 32'($urandom_range(0, 15)) << 2;
    endcase
  endfunction

  // ---------------- Main sequence -----------------------------------------
  initial begin
    int  rst_cnt;
    bit  gi, gd;
    rstn = 0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rstn = 1;

    // 1: data write wins the first conflict; instruction reads back the word.
    @(posedge clk); #1;
    d_req = 1; d_we = 4'hF; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
    i_req = 1; i_addr = 32'h10;
    @(negedge clk);
    chk("t1_d_gnt", 32'(d_gnt), 1);
    chk("t1_i_gnt", 32'(i_gnt), 0);
    chk("t1_ram_we", 32'(ram_we), 32'hF);
    @(posedge clk); #1;
    d_req = 0; d_we = 0;
    @(negedge clk);
    chk("t1_d_rvalid", 32'(d_rvalid), 1);
    chk("t1_d_err", 32'(d_err), 0);
    chk("t1_i_gnt2", 32'(i_gnt), 1);
    @(posedge clk); #1;
    i_req = 0;
    @(negedge clk);
    chk("t1_i_rvalid", 32'(i_rvalid), 1);
    chk("t1_i_rdata", i_rdata, 32'hDEADBEEF);

    // 2: byte write returns the old word (read-first), then the merged word.
    d_txn("t2_wr", 4'b0100, 32'h10, 32'h00AA0000, 32'hDEADBEEF, 1'b0);
    d_txn("t2_rd", 4'b0000, 32'h10, 32'h0, 32'hDEAABEEF, 1'b0);

    // 3: both ports held high alternate D, I, D, I after reset.
    do_reset();
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h10;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) begin
        chk($sformatf("t3_d_gnt%0d", k), 32'(d_gnt), 32'((k % 2) == 0));
        chk($sformatf("t3_i_gnt%0d", k), 32'(i_gnt), 32'((k % 2) == 1));
      end
      if (k > 0) begin
        chk($sformatf("t3_d_rv%0d", k), 32'(d_rvalid), 32'(((k - 1) % 2) == 0));
        chk($sformatf("t3_i_rv%0d", k), 32'(i_rvalid), 32'(((k - 1) % 2) == 1));
      end
      @(posedge clk); #1;
      if (k == 3) begin i_req = 0; d_req = 0; end
    end

    // 4: misaligned write faults and leaves the RAM untouched.
    d_txn("t4_mis", 4'hF, 32'h12, 32'h11111111, 32'h0, 1'b1);
    d_txn("t4_chk", 4'h0, 32'h10, 32'h0, 32'hDEAABEEF, 1'b0);

    // 5: range boundary.
    i_txn("t5_oor", 32'h1000, 32'h0, 1'b1);
    i_txn("t5_top", 32'hFFC, init_word(1023), 1'b0);

    // 6: reset while a response is in flight drops it.
    @(posedge clk); #1;
    d_req = 1; d_we = 0; d_addr = 32'h10;
    @(negedge clk);
    chk("t6_d_gnt", 32'(d_gnt), 1);
    #2 rstn = 0; d_req = 0;
    @(negedge clk);
    chk("t6_rv_inrst", 32'(d_rvalid), 0);
    @(posedge clk); #1 rstn = 1;
    @(negedge clk);
    chk("t6_rv_after", 32'(d_rvalid), 0);
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h0; d_req = 1; d_we = 0; d_addr = 32'h10;
    @(negedge clk);
    chk("t6_d_first", 32'(d_gnt), 1);
    chk("t6_i_first", 32'(i_gnt), 0);
    @(posedge clk); #1 d_req = 0;
    @(negedge clk);
    chk("t6_i_second", 32'(i_gnt), 1);
    @(posedge clk); #1 i_req = 0;

    // Randomized traffic: requesters hold until granted, occasional resets.
    rst_cnt = 0;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      gi = i_gnt; gd = d_gnt;
      @(posedge clk); #1;
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) rstn = 1;
      end else if ($urandom_range(0, 199) == 0) begin
        rstn = 0;
        rst_cnt = $urandom_range(1, 3);
      end
      if (!i_req || gi) begin
        i_req  = ($urandom_range(0, 2) != 0);
        i_addr = rand_addr();
      end
      if (!d_req || gd) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_addr  = rand_addr();
        d_we    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
        d_wdata = $urandom;
      end
    end
    rstn = 1;
    i_req = 0; d_req = 0; d_we = 0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares one single-port, byte-write-enable, read-first BRAM between two requesters: a read-only instruction-fetch port and a read/write data port. Performs round-robin arbitration, address range/alignment checking, and RAM command muxing. Returns a response one cycle after each grant. Sits between the rvj1 core's fetch/LSU interfaces and the testbench RAM.

Parameters:
SIZE, 1024, RAM depth in words
ADDR_WIDTH, 32, byte-address width of both ports and RAM
COL_WIDTH, 8, bits per byte-write column
NB_COL, 4, columns per word (word = NB_COL*COL_WIDTH bits)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
i_req  in  1  instruction read request
i_addr  in  ADDR_WIDTH  instruction byte address
i_gnt  out  1  instruction request accepted this cycle
i_rvalid  out  1  instruction response valid
i_rdata  out  NB_COL*COL_WIDTH  instruction read data
i_err  out  1  instruction response is an access fault
d_req  in  1  data request
d_we  in  NB_COL  data byte write strobes (all 0 = read)
d_addr  in  ADDR_WIDTH  data byte address
d_wdata  in  NB_COL*COL_WIDTH  data write data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  data response valid (reads and writes)
d_rdata  out  NB_COL*COL_WIDTH  data read data
d_err  out  1  data response is an access fault
ram_we  out  NB_COL  to RAM we
ram_addr  out  ADDR_WIDTH  to RAM addr (byte address, RAM uses addr>>2)
ram_di  out  NB_COL*COL_WIDTH  to RAM di
ram_dout  in  NB_COL*COL_WIDTH  from RAM dout (registered, 1-cycle latency)

Behaviour:
- Reset (rstn low, async): i_rvalid, d_rvalid, i_err, d_err = 0; i_rdata, d_rdata = 0; last_grant = INSTR, so data wins the first conflict. i_gnt, d_gnt, ram_we = 0 while in reset.
- Requesters hold req/addr/wdata stable until gnt. gnt is combinational from req and last_grant, at most one per cycle.
- Arbitration: only one req → grant it. Both → grant the port not in last_grant. last_grant updates on every grant.
- Granted cycle: ram_addr = granted addr; ram_di = d_wdata when data is granted, else 0. ram_we = d_we only if data is granted and the access is legal, else 0. With no grant: ram_we = 0, ram_addr holds its last value.
- Legal access: addr[1:0] == 0 and (addr >> 2) < SIZE. An illegal access is still granted, but ram_we is forced to 0 and the response carries err = 1 with rdata = 0.
- Response pipeline: one register stage records {valid, port, err}. In cycle N+1 after a grant in cycle N, the owning port's rvalid = 1 for exactly one cycle. Its rdata = ram_dout (read-first, so a write returns the old word) or 0 on error, and err is set as recorded. The other port's rvalid = 0.
- Throughput: one grant per cycle. Back-to-back grants yield back-to-back responses. No backpressure on responses.
- rdata and err hold their values when rvalid = 0.
- Reset mid-operation: an in-flight response is dropped and its rvalid is never asserted. The RAM contents are not touched.
- Width rule: the range compare uses addr[ADDR_WIDTH-1:2] zero-extended against SIZE. This gives no wrap-around aliasing, and addresses ≥ SIZE*4 fault.

Decomposition:
- Package ram_arb_pkg: port-id enum (PORT_INSTR = 0, PORT_DATA = 1); WORD_W = NB_COL*COL_WIDTH; a response-stage struct {valid, port, err}.
- Sub-module rr_arb2: 2-requester round-robin arbiter with the last_grant flop. Inputs req[1:0]; output one-hot gnt[1:0]; async reset to last = PORT_INSTR.

Test Plan:
1. After reset, d_req = 1, d_we = 4'hF, d_addr = 0x10, d_wdata = 0xDEADBEEF. Then i_req = 1, i_addr = 0x10 → d_gnt in cycle 0, d_rvalid in cycle 1 with d_err = 0; i_rdata = 0xDEADBEEF one cycle after i_gnt.
2. Byte write d_we = 4'b0100, d_wdata = 0x00AA0000 to 0x10 (which holds 0xDEADBEEF). Then data read of 0x10 → write response d_rdata = 0xDEADBEEF (read-first); following read = 0xDEAABEEF.
3. i_req and d_req both held high for 4 cycles after reset → grant order D, I, D, I. The rvalid of each port follows its grant by exactly 1 cycle.
4. d_addr = 0x12 (misaligned) with d_we = 4'hF → d_gnt = 1, ram_we = 0, next cycle d_rvalid = 1, d_err = 1, d_rdata = 0. RAM word 0x10 is unchanged.
5. i_addr = SIZE*4 (0x1000) → i_err = 1 with i_rdata = 0. i_addr = 0xFFC → i_err = 0.
6. Grant a data read, then assert rstn = 0 before the next clock edge → d_rvalid never asserts. After release, first conflict grants data.
